counter_8bit: RTL and testbench



---
 rtl/counter_8bit.sv | 54 +++++
 tb/tb_counter_8bit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/counter_8bit.sv
// counter_8bit: loadable up/down binary counter with synchronous reset and load.
// Priority at each rising edge: reset, then load, then step by +1/-1 (mod 2^WIDTH).
`default_nettype none

module counter_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             up_down,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;
  logic [WIDTH-1:0] count_step;
  logic [WIDTH-1:0] count_next;

  // Both directions are computed in parallel; natural overflow gives the wrap.
  assign count_inc  = count + WIDTH'(1);
  assign count_dec  = count - WIDTH'(1);
  assign count_step = up_down ? count_dec : count_inc;

  always_comb begin
    count_next = count_step;
    if (load) begin
      count_next = in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

`ifndef SYNTHESIS
  // Any cycle that neither resets nor loads must move the count by exactly one.
  property p_single_step;
    @(posedge clk) disable iff (reset)
      !load |=> (count == ($past(up_down) ? $past(count) - WIDTH'(1)
                                          : $past(count) + WIDTH'(1)));
  endproperty

  a_single_step: assert property (p_single_step);
`endif

endmodule

`default_nettype wire

// File: tb/tb_counter_8bit.sv
// Directed, table-driven bench for counter_8bit with hand-computed expectations.
`default_nettype none

module tb_counter_8bit;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] in_v;
  logic       up_down;
  logic [7:0] count;

  int checks;
  int errors;

  typedef struct {
    logic       reset;
    logic       load;
    logic [7:0] in;
    logic       up_down;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  counter_8bit #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .in      (in_v),
    .up_down (up_down),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic l, input logic [7:0] d,
                              input logic ud, input logic [7:0] e, input string n);
    vec_t v;
    v.reset = r; v.load = l; v.in = d; v.up_down = ud; v.exp = e; v.name = n;
    vecs.push_back(v);
  endfunction

  task automatic check(input logic [7:0] exp, input string name);
    checks++;
    if (count !== exp) begin
      errors++;
      $display("FAIL %s: count=%h expected=%h at %0t", name, count, exp, $time);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic l, input logic [7:0] d, input logic ud);
    @(negedge clk);
    reset = r; load = l; in_v = d; up_down = ud;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0; load = 1'b0; in_v = 8'h00; up_down = 1'b0;

    add(1, 0, 8'h00, 0, 8'h00, "reset");
    for (int i = 1; i <= 10; i++) add(0, 0, 8'h00, 0, 8'(i), "count_up");
    add(0, 1, 8'h39, 0, 8'h39, "load_39");
    add(0, 0, 8'h00, 1, 8'h38, "down_1");
    add(0, 0, 8'h00, 1, 8'h37, "down_2");
    add(0, 0, 8'h00, 1, 8'h36, "down_3");
    add(0, 0, 8'h00, 1, 8'h35, "down_4");
    add(0, 0, 8'h00, 1, 8'h34, "down_5");
    add(0, 1, 8'hFE, 0, 8'hFE, "load_FE");
    add(0, 0, 8'h00, 0, 8'hFF, "wrap_up_FF");
    add(0, 0, 8'h00, 0, 8'h00, "wrap_up_00");
    add(0, 0, 8'h00, 0, 8'h01, "wrap_up_01");
    add(0, 1, 8'h01, 1, 8'h01, "load_01");
    add(0, 0, 8'h00, 1, 8'h00, "wrap_dn_00");
    add(0, 0, 8'h00, 1, 8'hFF, "wrap_dn_FF");
    add(0, 0, 8'h00, 1, 8'hFE, "wrap_dn_FE");
    add(1, 1, 8'hAA, 0, 8'h00, "reset_beats_load");
    add(0, 1, 8'h10, 1, 8'h10, "load_ignores_dir");
    add(0, 0, 8'h00, 1, 8'h0F, "first_dec_after_load");
    add(0, 1, 8'h1F, 0, 8'h1F, "load_1F");
    add(0, 0, 8'h00, 0, 8'h20, "up_to_20");
    add(1, 0, 8'h00, 0, 8'h00, "mid_reset");
    add(0, 0, 8'h00, 0, 8'h01, "resume_up");
    add(1, 0, 8'h00, 1, 8'h00, "mid_reset_dn");
    add(0, 0, 8'h00, 1, 8'hFF, "resume_down");
    add(0, 1, 8'h04, 0, 8'h04, "load_04");
    add(0, 0, 8'h00, 0, 8'h05, "dir_up_05");
    add(0, 0, 8'h00, 1, 8'h04, "dir_switch_04");
    add(0, 1, 8'h04, 1, 8'h04, "hold_via_load");

    foreach (vecs[i]) begin
      step(vecs[i].reset, vecs[i].load, vecs[i].in, vecs[i].up_down);
      check(vecs[i].exp, vecs[i].name);
    end

    // Sub-cycle load pulse between edges must not be captured.
    step(0, 0, 8'h77, 0);
    check(8'h05, "pre_pulse_up");
    @(negedge clk);
    #1 load = 1'b1;
    #2 load = 1'b0;
    @(posedge clk);
    #1;
    check(8'h06, "pulse_ignored_up");
    @(negedge clk);
    up_down = 1'b1;
    #1 load = 1'b1;
    #2 load = 1'b0;
    @(posedge clk);
    #1;
    check(8'h05, "pulse_ignored_down");

    // Reset held across several edges keeps count at zero.
    step(1, 0, 8'h00, 0);
    check(8'h00, "reset_hold_1");
    step(1, 1, 8'h55, 1);
    check(8'h00, "reset_hold_2");
    step(0, 0, 8'h00, 1);
    check(8'hFF, "after_hold_down");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
